// File: rtl/handshake_pkg.sv
// Shared types and helpers for the multi-channel handshake arbiter.
// Provides the tag-width function and the per-channel state encoding.
package handshake_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } ch_st_e;

    // Tag width: at least one bit, even for a single channel.
    function automatic int clog2w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/handshake_arb_syn_if.sv
// Bus bundle between CH producers, the arbiter and the shared sink.
// Ports: sready/din/sidle (source side), dbusy/dvalid/dout/dch (sink side).
interface handshake_arb_syn_if
    import handshake_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CH    = 4
);

    localparam int CHW = clog2w(CH);

    logic [CH-1:0]       sready;
    logic [CH*WIDTH-1:0] din;
    logic [CH-1:0]       sidle;
    logic                dbusy;
    logic                dvalid;
    logic [WIDTH-1:0]    dout;
    logic [CHW-1:0]      dch;

    modport slave (
        input  sready,
        input  din,
        input  dbusy,
        output sidle,
        output dvalid,
        output dout,
        output dch
    );

    modport master (
        output sready,
        output din,
        output dbusy,
        input  sidle,
        input  dvalid,
        input  dout,
        input  dch
    );

endinterface

// File: rtl/rr_pick_syn.sv
// Combinational round-robin picker: first set req bit from ptr upward.
// Ports: req (requests), ptr (start index), any (a request exists), win.
module rr_pick_syn
    import handshake_pkg::*;
#(
    parameter int CH  = 4,
    parameter int CHW = clog2w(CH)
)(
    input  logic [CH-1:0]  req,
    input  logic [CHW-1:0] ptr,
    output logic           any,
    output logic [CHW-1:0] win
);

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        any = 1'b0;
        win = '0;
        for (int k = CH - 1; k >= 0; k--) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= CH) begin
                idx = idx - CH;
            end
            if (req[idx]) begin
                any = 1'b1;
                win = CHW'(idx);
            end
        end
    end

endmodule

// File: rtl/handshake_arb_syn.sv
// Single-clock CH-channel holding-register arbiter onto one sink port.
// Ports: clk, rst (async, active high), bus (slave view of the bundle).
module handshake_arb_syn
    import handshake_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CH    = 4
)(
    input  logic              clk,
    input  logic              rst,
    handshake_arb_syn_if.slave bus
);

    localparam int CHW = clog2w(CH);

    ch_st_e           st_q [CH];
    ch_st_e           st_d [CH];
    logic [CH-1:0]    pend;
    logic [WIDTH-1:0] hold [CH];
    logic [CHW-1:0]   ptr;
    logic [CHW-1:0]   win;
    logic             any;
    logic             grant;
    logic             dvalid_q;
    logic [WIDTH-1:0] dout_q;
    logic [CHW-1:0]   dch_q;

    always_comb begin
        pend = '0;
        for (int i = 0; i < CH; i++) begin
            pend[i] = (st_q[i] == ST_PEND);
        end
    end

    rr_pick_syn #(
        .CH  (CH),
        .CHW (CHW)
    ) u_pick (
        .req (pend),
        .ptr (ptr),
        .any (any),
        .win (win)
    );

    assign grant = any & ~bus.dbusy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                st_q[i] <= ST_IDLE;
            end
        end else begin
            st_q <= st_d;
        end
    end

    // Capture needs IDLE and release needs PEND, so the two never
    // collide on one channel.
    always_comb begin
        st_d = st_q;
        for (int i = 0; i < CH; i++) begin
            unique case (st_q[i])
                ST_IDLE: begin
                    if (bus.sready[i]) begin
                        st_d[i] = ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (grant && (win == CHW'(i))) begin
                        st_d[i] = ST_IDLE;
                    end
                end
                default: st_d[i] = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                hold[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                if ((st_q[i] == ST_IDLE) && bus.sready[i]) begin
                    hold[i] <= bus.din[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Pointer moves just past the winner, wrapping at CH-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvalid_q <= 1'b0;
            dout_q   <= '0;
            dch_q    <= '0;
            ptr      <= '0;
        end else if (grant) begin
            dvalid_q <= 1'b1;
            dout_q   <= hold[win];
            dch_q    <= win;
            ptr      <= (win == CHW'(CH - 1)) ? '0 : win + 1'b1;
        end else begin
            dvalid_q <= 1'b0;
        end
    end

    assign bus.sidle  = ~pend;
    assign bus.dvalid = dvalid_q;
    assign bus.dout   = dout_q;

    generate
        if (CH == 1) begin : g_one
            assign bus.dch = '0;
        end else begin : g_many
            assign bus.dch = dch_q;
        end
    endgenerate

endmodule

// File: tb/tb_handshake_arb_syn.sv
// Directed bench for handshake_arb_syn: CH=4 main instance, CH=3 wrap.
// Drives inputs #1 after the rising edge and checks at that same point.
module tb_handshake_arb_syn;

    logic clk = 1'b0;
    logic rst;
    int   vecs = 0;
    int   errs = 0;
    int   n;

    handshake_arb_syn_if #(.WIDTH(8), .CH(4)) b4 ();
    handshake_arb_syn_if #(.WIDTH(8), .CH(3)) b3 ();

    handshake_arb_syn #(.WIDTH(8), .CH(4)) u4 (
        .clk (clk),
        .rst (rst),
        .bus (b4.slave)
    );

    handshake_arb_syn #(.WIDTH(8), .CH(3)) u3 (
        .clk (clk),
        .rst (rst),
        .bus (b3.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic word(input int ch, input logic [7:0] w);
        b4.din[ch*8 +: 8] = w;
    endtask

    task automatic beat(input string tag, input logic [7:0] d,
                        input logic [1:0] c);
        chk({tag, "_v"}, b4.dvalid, 1);
        chk({tag, "_d"}, b4.dout, d);
        chk({tag, "_c"}, b4.dch, c);
    endtask

    initial begin
        rst       = 1'b1;
        b4.sready = '0;
        b4.din    = '0;
        b4.dbusy  = 1'b0;
        b3.sready = '0;
        b3.din    = '0;
        b3.dbusy  = 1'b0;
        tick();
        tick();
        chk("rst_sidle", b4.sidle, 4'hF);
        chk("rst_dvalid", b4.dvalid, 0);
        chk("rst_dout", b4.dout, 0);
        chk("rst_dch", b4.dch, 0);
        rst = 1'b0;
        tick();

        b4.sready = 4'b0001;
        word(0, 8'hA5);
        tick();
        chk("t1_sidle0", b4.sidle[0], 0);
        chk("t1_early", b4.dvalid, 0);
        b4.sready = '0;
        tick();
        beat("t1", 8'hA5, 0);
        chk("t1_sidle_back", b4.sidle[0], 1);
        tick();
        chk("t1_pulse", b4.dvalid, 0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        b4.sready = 4'hF;
        word(0, 8'h11);
        word(1, 8'h22);
        word(2, 8'h33);
        word(3, 8'h44);
        tick();
        b4.sready = '0;
        tick();
        beat("rr0", 8'h11, 0);
        tick();
        beat("rr1", 8'h22, 1);
        tick();
        beat("rr2", 8'h33, 2);
        tick();
        beat("rr3", 8'h44, 3);
        tick();
        chk("rr_end", b4.dvalid, 0);
        b4.sready = 4'b1010;
        word(1, 8'h55);
        word(3, 8'h77);
        tick();
        b4.sready = '0;
        tick();
        beat("rl1", 8'h55, 1);
        tick();
        beat("rl3", 8'h77, 3);
        tick();
        chk("rl_end", b4.dvalid, 0);

        b4.dbusy  = 1'b1;
        b4.sready = 4'b0101;
        word(0, 8'hA0);
        word(2, 8'hC2);
        tick();
        b4.sready = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_dvalid", b4.dvalid, 0);
            chk("bp_sidle", b4.sidle, 4'b1010);
        end
        b4.dbusy = 1'b0;
        tick();
        beat("bp0", 8'hA0, 0);
        tick();
        beat("bp2", 8'hC2, 2);
        tick();
        chk("bp_end", b4.dvalid, 0);

        b4.dbusy  = 1'b1;
        b4.sready = 4'b0010;
        word(1, 8'h5A);
        tick();
        word(1, 8'hFF);
        tick();
        tick();
        chk("ig_sidle", b4.sidle, 4'b1101);
        b4.sready = '0;
        b4.dbusy  = 1'b0;
        tick();
        beat("ig", 8'h5A, 1);
        n = 0;
        repeat (4) begin
            tick();
            if (b4.dvalid) n++;
        end
        chk("ig_once", n, 0);

        b3.din    = {8'h32, 8'h31, 8'h30};
        b3.sready = 3'b111;
        tick();
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("w3_v", b3.dvalid, 1);
            chk("w3_c", b3.dch, k % 3);
            chk("w3_d", b3.dout, 8'h30 + k % 3);
            chk("w3_ptr", (u3.ptr < 2'd3) ? 1 : 0, 1);
        end
        b3.sready = '0;

        b4.dbusy  = 1'b1;
        b4.sready = 4'b0111;
        word(0, 8'hE0);
        word(1, 8'hE1);
        word(2, 8'hE2);
        tick();
        b4.sready = '0;
        chk("mr_sidle_pre", b4.sidle, 4'b1000);
        rst = 1'b1;
        #1;
        chk("mr_dvalid", b4.dvalid, 0);
        chk("mr_dout", b4.dout, 0);
        chk("mr_dch", b4.dch, 0);
        chk("mr_sidle", b4.sidle, 4'hF);
        tick();
        rst      = 1'b0;
        b4.dbusy = 1'b0;
        n = 0;
        repeat (6) begin
            tick();
            if (b4.dvalid) n++;
        end
        chk("mr_stale", n, 0);
        chk("mr_sidle_end", b4.sidle, 4'hF);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/handshake_arb_syn.md
Name: handshake_arb_syn

Overview:
- Single-clock, multi-channel successor to the two-domain handshake block.
- Accepts one word per source channel into a per-channel holding register. Round-robin arbitrates pending words onto one sink port with dbusy backpressure.
- Tags each delivered word with its channel number.
- Sits between CH producer engines and one shared consumer in the same clock domain.

Parameters:
- WIDTH, 8, data word width in bits.
- CH, 4, number of source channels; legal range 1..16, need not be a power of 2.
- CHW, max(1, clog2(CH)), derived; width of the channel tag. Must not be overridden.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- sready  input  CH  per-channel request; bit i offers din slice i.
- din  input  CH*WIDTH  channel i data occupies bits [i*WIDTH +: WIDTH].
- sidle  output  CH  bit i high means channel i holding register is empty and can accept.
- dbusy  input  1  sink busy; no word is delivered in a cycle where dbusy is high.
- dvalid  output  1  registered one-cycle pulse per delivered word.
- dout  output  WIDTH  delivered word, valid when dvalid is high.
- dch  output  CHW  source channel of dout, valid when dvalid is high.

Behaviour:
- Reset values (rst high, asynchronous):
  - all pend[i] = 0, so sidle = all ones;
  - hold[i] = 0, ptr = 0;
  - dvalid = 0, dout = 0, dch = 0.
- Per-channel 2-state FSM, IDLE (pend=0) / PEND (pend=1). sidle[i] = !pend[i], driven directly from the flop.
  - IDLE -> PEND when sready[i] is high at a clock edge; hold[i] <= din slice i on the same edge.
  - PEND -> IDLE on the edge at which channel i is granted.
  - In PEND, sready[i] and din slice i are ignored; hold[i] is stable.
- Grant rule, evaluated every cycle:
  - If dbusy == 0 and any pend is set, winner w = first i with pend[i]=1, searching ptr, ptr+1, ... modulo CH.
  - On the edge: dvalid <= 1, dout <= hold[w], dch <= w, pend[w] <= 0, ptr <= (w == CH-1) ? 0 : w+1.
  - Otherwise: dvalid <= 0; dout, dch and ptr hold their values.
- Latency: sready at edge t -> pend at t+1 -> dvalid high in cycle t+2 at the earliest, when dbusy is low and no competing channel wins.
- Throughput:
  - sink: one word per cycle while words are pending;
  - single channel: one word per 2 cycles, because a channel re-enters IDLE only one cycle after its grant.
- Simultaneous events:
  - Capture and grant can never hit the same channel in one cycle, since capture requires IDLE and grant requires PEND.
  - Capture on channel j and grant of channel k != j in the same cycle are both performed.
- dbusy high for N cycles: no grants and dvalid stays 0. All pend bits and hold data are retained, and new captures on idle channels continue.
- Fairness: a channel in PEND is granted within CH cycles of dbusy-low time.
- ptr wraps CH-1 -> 0 for any CH. ptr never holds a value >= CH.
- CH = 1: the arbiter degenerates to pass-through and dch is tied to 0.
- Reset mid-operation: pending words are discarded with no dvalid pulse. ptr returns to 0.
- No combinational path from any input to any output.

Decomposition:
- Shared package handshake_pkg:
  - clog2-based width function used for CHW;
  - a channel-state encoding constant pair (ST_IDLE = 0, ST_PEND = 1).
- Sub-module rr_pick_syn: purely combinational round-robin priority picker.
  - Inputs: req[CH], ptr[CHW].
  - Outputs: any, win[CHW].
  - Instantiated once. The top-level module owns pend, hold, ptr and the output registers.

Test Plan:
- Reset then single word: WIDTH=8, CH=4, dbusy=0; sready=0001 and din[7:0]=8'hA5 for one cycle.
  - Required: sidle[0]=0 next cycle; dvalid pulses 2 cycles after the request with dout=A5, dch=0; sidle[0]=1 the cycle after the grant.
- Round-robin order: load all 4 channels simultaneously with 11,22,33,44 (ptr=0).
  - Required: 4 consecutive dvalid pulses delivering 11/0, 22/1, 33/2, 44/3.
  - Then reload channels 1 and 3; required order is ch1 then ch3, since ptr = 0 after the wrap.
- Backpressure: channels 0 and 2 pending, dbusy=1 for 10 cycles.
  - Required: dvalid stays 0 and sidle stays 1010 low-bits held.
  - After dbusy falls: ch0 then ch2 on consecutive cycles.
- Ignore while pending: ch1 holds 5A; assert sready[1] with din=FF during PEND under dbusy=1.
  - Required: the delivered word is 5A, and exactly one dvalid pulse occurs for ch1.
- Non-power-of-2 wrap: CH=3, all channels pending continuously.
  - Required: dch sequence 0,1,2,0,1,2, and ptr never equals 3.
- Reset mid-operation: 3 channels pending, assert rst for 1 cycle.
  - Required: dvalid=0, dout=0, dch=0 immediately, sidle=all ones.
  - After release, no stale words are delivered.
